uart_rx_seq_detect: RTL
=======================

// Module: uart_rx_seq_detect
// PURPOSE
//  Upstream neighbour of the retransmit stage. Deframes 8N1 UART serial input with 16x oversampling,
//  emits each received byte, and raises sticky 'equal' when the last SEQ_LEN bytes match a programmed
//  sequence. Its 'equal' output drives the retransmit stage's 'equal' input; 'in' is shared with it.
// PARAMETERS
//  CLKS_PER_BIT  16           clk cycles per serial bit (even, >=4)
//  SEQ_LEN       3            number of bytes in the match sequence (1..8)
//  MATCH_SEQ     24'h393634   expected bytes, oldest in MS byte, width 8*SEQ_LEN ("964")
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  asynchronous reset, active-low
//  in         in   1  serial line, idle high, asynchronous to clk
//  rx_data    out  8  last good received byte, LSB received first
//  rx_valid   out  1  one-cycle pulse, rx_data updated this cycle
//  frame_err  out  1  one-cycle pulse, stop bit sampled low
//  equal      out  1  sticky match flag, cleared only by reset
// BEHAVIOUR
//  Reset (rst=0): rx_data=8'h00, rx_valid=0, frame_err=0, equal=0, history cleared, FSM=IDLE,
//   synchroniser flops preset to 1. Reset mid-frame aborts the frame, no partial byte is ever emitted.
//  Input: 2-flop synchroniser on 'in'; all decisions use the synchronised value (2-cycle delay).
//  Bit counter cnt 0..CLKS_PER_BIT-1; mid-bit = cnt==CLKS_PER_BIT/2-1.
//  FSM:
//   IDLE  : sync_in==0 -> START, cnt=0.
//   START : at mid-bit, sync_in==0 -> DATA, cnt=0, bit_idx=0; sync_in==1 -> IDLE (glitch, no output).
//   DATA  : every CLKS_PER_BIT cycles after start mid-point, shift sync_in into bit bit_idx;
//           after bit 7 -> STOP.
//   STOP  : at stop mid-point: sync_in==1 -> rx_data<=shift, rx_valid=1, -> IDLE.
//           sync_in==0 -> frame_err=1, byte discarded, history untouched, -> BREAK.
//   BREAK : wait for sync_in==1, then -> IDLE (line held low never re-triggers start).
//  Receiver returns to IDLE at stop mid-bit, so back-to-back frames with no idle gap are accepted.
//  Latency: rx_valid asserts 2 + 9.5*CLKS_PER_BIT cycles (nominal) after the start-bit falling edge.
//  Match history: SEQ_LEN x 8 shift register; on rx_valid shifts left, new byte enters LS byte.
//   equal <= 1 the cycle after rx_valid if {history after shift}==MATCH_SEQ; once 1 stays 1.
//   Fewer than SEQ_LEN bytes since reset: no match possible (track fill count, saturating at SEQ_LEN).
//   Overlapping matches allowed (sliding window, no restart after a mismatch needed).
//  rx_valid and frame_err never assert in the same cycle.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE, START, DATA, STOP, BREAK), DATA_BITS=8 constant.
//  One sub-module: uart_rx_core (synchroniser + FSM + shifter, outputs rx_data/rx_valid/frame_err);
//  top holds the history register, fill counter and equal flag.
// TESTING  (clk period 2 time units, bit = 32 units)
//  1 Reset then idle line 100 bit-times -> all outputs at reset values, no rx_valid.
//  2 Frames 0x39,0x36,0x34 back-to-back -> three rx_valid pulses with those bytes; equal rises 1 cycle
//    after third pulse and holds through 100 further idle bit-times.
//  3 After test 2 pulse rst low 2 bit-times, send 0x35 -> rx_valid with 0x35, equal stays 0.
//  4 Send 0x39,0x36,0x35,0x39,0x36,0x34 -> equal 0 until sixth byte, then 1 (sliding window).
//  5 Low glitch of 4 clocks on idle line -> no rx_valid, FSM back in IDLE; next 0x39 received cleanly.
//  6 Frame 0x39 with stop bit low, line low 3 bit-times -> one frame_err pulse, no rx_valid,
//    history unchanged; following 0x34 received correctly.

Source files
------------

// File: rtl/uart_rx_seq_detect_pkg.sv
// Shared types and constants for the UART receiver with sequence detection.
package uart_rx_seq_detect_pkg;

  localparam int unsigned DataBits = 8;

  // Receiver FSM states
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

endpackage

// File: rtl/uart_rx_seq_detect_if.sv
// Serial input and receive-side result signals of the UART sequence detector.
interface uart_rx_seq_detect_if;
  import uart_rx_seq_detect_pkg::*;

  logic                in;
  logic [DataBits-1:0] rx_data;
  logic                rx_valid;
  logic                frame_err;
  logic                equal;

  // Line driver / result consumer side
  modport master (output in, input rx_data, rx_valid, frame_err, equal);
  // Receiver side
  modport slave (input in, output rx_data, rx_valid, frame_err, equal);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART deframer: 2-flop synchroniser, oversampled bit timing FSM, data shifter.
module uart_rx_core
  import uart_rx_seq_detect_pkg::*;
#(
  parameter int unsigned ClksPerBit = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rx_i,
  output logic [DataBits-1:0] rx_data_o,
  output logic                rx_valid_o,
  output logic                frame_err_o
);

  localparam int unsigned CntW = $clog2(ClksPerBit);
  localparam int unsigned IdxW = $clog2(DataBits);
  localparam logic [CntW-1:0] MidCnt  = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DataBits - 1);

  logic [1:0]          sync_q;
  logic                sync_in;
  rx_state_e           state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic [DataBits-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  assign sync_in = sync_q[1];

  // State register, synchroniser and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;  // preset so an idle line is not seen as a start bit
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: bit timing, bit index and data capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!sync_in) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == MidCnt) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sync_in ? StIdle : StData;
        end
      end
      StData: begin
        // Full bit period after the start mid-point lands on each data mid-point
        if (cnt_q == LastCnt) begin
          cnt_d          = '0;
          shift_d[idx_q] = sync_in;
          idx_d          = idx_q + 1'b1;
          if (idx_q == LastIdx) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = sync_in ? StIdle : StBreak;
        end
      end
      StBreak: begin
        // A held-low line must return high before a new start is accepted
        cnt_d = '0;
        if (sync_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: one-cycle result pulses decided at the stop-bit mid-point
  always_comb begin
    valid_d = 1'b0;
    err_d   = 1'b0;
    data_d  = data_q;
    if (state_q == StStop && cnt_q == LastCnt) begin
      if (sync_in) begin
        valid_d = 1'b1;
        data_d  = shift_q;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = err_q;

endmodule

// File: rtl/uart_rx_seq_detect.sv
// UART receiver with a sticky flag for the last SeqLen bytes matching MatchSeq.
module uart_rx_seq_detect
  import uart_rx_seq_detect_pkg::*;
#(
  parameter int unsigned                  ClksPerBit = 16,
  parameter int unsigned                  SeqLen     = 3,
  parameter logic [DataBits*SeqLen-1:0]   MatchSeq   = 24'h393634
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  uart_rx_seq_detect_if.slave  bus_io
);

  localparam int unsigned HistW = DataBits * SeqLen;
  localparam int unsigned FillW = $clog2(SeqLen + 1);

  logic [DataBits-1:0] rx_data;
  logic                rx_valid;
  logic                frame_err;
  logic [HistW-1:0]    hist_q, hist_d, hist_shift;
  logic [FillW-1:0]    fill_q, fill_d;
  logic                equal_q, equal_d;

  uart_rx_core #(
    .ClksPerBit (ClksPerBit)
  ) u_core (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (bus_io.in),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .frame_err_o (frame_err)
  );

  // Oldest byte falls off the top, newest enters the bottom
  assign hist_shift = HistW'({hist_q, rx_data});

  // History, fill count and sticky match registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q  <= '0;
      fill_q  <= '0;
      equal_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      equal_q <= equal_d;
    end
  end

  // Update history on each good byte; match only once the window is full
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    equal_d = equal_q;
    if (rx_valid) begin
      hist_d = hist_shift;
      if (fill_q != FillW'(SeqLen)) fill_d = fill_q + 1'b1;
      if (fill_q >= FillW'(SeqLen - 1) && hist_shift == MatchSeq) equal_d = 1'b1;
    end
  end

  assign bus_io.rx_data   = rx_data;
  assign bus_io.rx_valid  = rx_valid;
  assign bus_io.frame_err = frame_err;
  assign bus_io.equal     = equal_q;

endmodule
